cis_frame_sequencer: RTL and testbench
======================================

# cis_frame_sequencer

Frame-level sequencer that drives the CIS_Control pattern engine through one complete frame. It times the exposure, then issues one integration trigger per pixel, each held for a guaranteed pulse width. It tracks the pattern engine's `running` handshake and walks row and column indices, reporting per-pixel completion and end of frame. It sits between the run-control registers and CIS_Control; its `integration` output drives CIS_Control's `integration` input directly.

## Interface
- `ROW_W`, 10: row counter / `num_rows` width
- `COL_W`, 10: column counter / `num_cols` width
- `EXP_W`, 24: exposure counter width
- `TO_W`, 20: timeout counter width
- `TRIG_WIDTH`, 8: integration pulse width in clk cycles (≥2)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  frame request; accepted only in IDLE
- `abort`  in  1  cancel frame; wins over `start` in the same cycle
- `num_rows`  in  ROW_W  rows per frame; sampled at accepted start
- `num_cols`  in  COL_W  columns per frame; sampled at accepted start
- `exposure_ticks`  in  EXP_W  exposure length in cycles; sampled at start
- `timeout_cycles`  in  TO_W  handshake timeout; 0 disables; sampled at start
- `running`  in  1  busy flag from CIS_Control
- `integration`  out  1  trigger to CIS_Control (registered)
- `row_idx`  out  ROW_W  current pixel row
- `col_idx`  out  COL_W  current pixel column
- `pixel_valid`  out  1  one-cycle pulse: pixel at (`row_idx`, `col_idx`) finished
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle end-of-frame pulse
- `error`  out  1  sticky handshake-timeout flag

## Operation
- States: IDLE, EXPOSE, TRIG, WAIT_START, WAIT_END, ADVANCE, DONE.
- IDLE, `start`=1, `abort`=0:
  - latch the four config inputs
  - clear `error`, zero `row_idx`/`col_idx`
  - if `num_rows`=0 or `num_cols`=0, go to DONE
  - else if `exposure_ticks`=0, go to TRIG
  - else go to EXPOSE
- EXPOSE: stays exactly `exposure_ticks` cycles, then TRIG. Exposure runs once per frame.
- TRIG: `integration`=1 for exactly TRIG_WIDTH cycles, then WAIT_START.
- WAIT_START: wait for `running`=1, then WAIT_END.
- WAIT_END: wait for `running`=0, then ADVANCE.
- Timeout (`timeout_cycles`≠0):
  - One shared counter, reset on entry to WAIT_START and again on entry to WAIT_END.
  - If the counter reaches `timeout_cycles` while the awaited level is absent, set `error`=1 and go to IDLE. No `done`, no `pixel_valid`.
- ADVANCE (one cycle):
  - `pixel_valid`=1, with the indices of the pixel just completed.
  - If last pixel (row=`num_rows`-1, col=`num_cols`-1), go to DONE.
  - Otherwise, if col=`num_cols`-1, col wraps to 0 and row increments; else col increments. Then go to TRIG.
- DONE: `done`=1 for one cycle, then IDLE. Indices hold their final values.
- `abort` in any non-IDLE state:
  - next state is IDLE; `integration` drops at the next edge
  - no `done`, no `pixel_valid`; `error` unchanged
- `start` in any non-IDLE state is ignored. Config changes mid-frame have no effect.
- `reset`: asynchronously forces IDLE and sets every output to 0, counters to 0. Applies mid-frame as well.

## Timing
- All outputs are registered.
- Accepted start at edge N: `busy`=1 from N+1.
- Zero-size frame: `done`=1 in cycle N+1 and `busy`=0 from N+2. No `integration` pulse.
- `exposure_ticks`=E>0: `integration` rises at edge N+1+E.
- `exposure_ticks`=0: `integration` rises at edge N+1.
- Each `integration` pulse is exactly TRIG_WIDTH cycles wide. Pulses are never merged back-to-back: at least 3 cycles low between pulses (WAIT_START, WAIT_END, ADVANCE).
- `running` already high when WAIT_START is entered: WAIT_START lasts one cycle.
- `pixel_valid` and `done` are never high in the same cycle.
- `done` is one cycle after the last `pixel_valid`.

## Test plan
- Reset: assert `reset` asynchronously during WAIT_END of a frame → all outputs 0 within the same cycle. Start after release → normal frame.
- 2×3 frame, E=10, TRIG_WIDTH=8. CIS_Control model raises `running` 2 cycles after `integration` falls and holds it 48 cycles → 6 `integration` pulses, each 8 cycles wide. `pixel_valid` order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Single `done`; `error`=0.
- `num_rows`=0 → `done` one cycle after start; `integration` never asserted. Repeat with E=0, 1×1 frame → `integration` rises the cycle after start.
- Timeout: `timeout_cycles`=100, `running` held 0 → `error`=1 exactly 100 cycles after entering WAIT_START; `busy` falls; no `done`. Next start clears `error`.
- Timeout stuck high: `timeout_cycles`=0, `running` stuck 1 for 10 000 cycles → no `error`; the frame completes once `running` falls.
- Abort and start interaction: `abort` during the second pixel's WAIT_END → IDLE next cycle, no further `pixel_valid`, no `done`. `start` pulses during a frame → ignored. `start`+`abort` together in IDLE → stays IDLE.

Source files
------------

// File: rtl/cis_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cis_frame_sequencer
//
// Frame-level sequencer for the CIS_Control pattern engine. On an accepted
// start it times the exposure once, then walks every pixel of the frame:
// an integration pulse of exactly TRIG_WIDTH cycles, a wait for CIS_Control
// to raise `running`, a wait for it to drop again, and a one-cycle advance
// that reports the finished pixel and moves the row/column indices.
//
// Every output is a register fed from the current state, so outputs follow
// the state register by one clock. `abort` is folded into those registers
// so the pulse outputs drop at the very next edge.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   start           frame request, accepted only while idle
//   abort           cancel the current frame (wins over start)
//   num_rows        rows per frame, sampled at accepted start
//   num_cols        columns per frame, sampled at accepted start
//   exposure_ticks  exposure length in cycles, sampled at accepted start
//   timeout_cycles  handshake timeout, 0 disables, sampled at accepted start
//   running         busy flag from CIS_Control
//   integration     trigger to CIS_Control
//   row_idx         current pixel row
//   col_idx         current pixel column
//   pixel_valid     one-cycle pulse: pixel at (row_idx, col_idx) finished
//   busy            high whenever a frame is in progress
//   done            one-cycle end-of-frame pulse
//   error           sticky handshake-timeout flag, cleared by next start
// ---------------------------------------------------------------------------
module cis_frame_sequencer #(
  parameter int ROW_W      = 10,
  parameter int COL_W      = 10,
  parameter int EXP_W      = 24,
  parameter int TO_W       = 20,
  parameter int TRIG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [COL_W-1:0] num_cols,
  input  logic [EXP_W-1:0] exposure_ticks,
  input  logic [TO_W-1:0]  timeout_cycles,
  input  logic             running,
  output logic             integration,
  output logic [ROW_W-1:0] row_idx,
  output logic [COL_W-1:0] col_idx,
  output logic             pixel_valid,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Pulse-width counter only needs to reach TRIG_WIDTH-1.
  localparam int TW_W = (TRIG_WIDTH > 2) ? $clog2(TRIG_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPOSE,
    S_TRIG,
    S_WAIT_START,
    S_WAIT_END,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Frame configuration captured at the accepted start.
  logic [ROW_W-1:0] rows_cfg;
  logic [COL_W-1:0] cols_cfg;
  logic [EXP_W-1:0] exp_cfg;
  logic [TO_W-1:0]  to_cfg;

  // Working counters.
  logic [EXP_W-1:0] exp_cnt;
  logic [TW_W-1:0]  trig_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col_cnt;

  logic accept;
  logic exp_last;
  logic trig_last;
  logic to_hit;
  logic last_col;
  logic last_row;
  logic timeout_evt;

  assign accept    = (state == S_IDLE) && start && !abort;
  assign exp_last  = (exp_cnt == exp_cfg - EXP_W'(1));
  assign trig_last = (trig_cnt == TW_W'(TRIG_WIDTH - 1));
  // The shared wait counter restarts at 0 on each wait-state entry, so the
  // timeout fires on the to_cfg-th cycle spent waiting.
  assign to_hit    = (to_cfg != '0) && (to_cnt == to_cfg - TO_W'(1));
  assign last_col  = (col_cnt == cols_cfg - COL_W'(1));
  assign last_row  = (row_cnt == rows_cfg - ROW_W'(1));

  // ---- state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---- next-state decode ----
  always_comb begin
    next_state  = state;
    timeout_evt = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if ((num_rows == '0) || (num_cols == '0)) begin
            next_state = S_DONE;
          end else if (exposure_ticks == '0) begin
            next_state = S_TRIG;
          end else begin
            next_state = S_EXPOSE;
          end
        end
      end
      S_EXPOSE: begin
        if (exp_last) begin
          next_state = S_TRIG;
        end
      end
      S_TRIG: begin
        if (trig_last) begin
          next_state = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // An awaited level that shows up on the timeout cycle still counts.
        if (running) begin
          next_state = S_WAIT_END;
        end else if (to_hit) begin
          next_state  = S_IDLE;
          timeout_evt = 1'b1;
        end
      end
      S_WAIT_END: begin
        if (!running) begin
          next_state = S_ADVANCE;
        end else if (to_hit) begin
          next_state  = S_IDLE;
          timeout_evt = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (last_row && last_col) begin
          next_state = S_DONE;
        end else begin
          next_state = S_TRIG;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE and leaves error untouched.
    if ((state != S_IDLE) && abort) begin
      next_state  = S_IDLE;
      timeout_evt = 1'b0;
    end
  end

  // ---- configuration and counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_cfg <= '0;
      cols_cfg <= '0;
      exp_cfg  <= '0;
      to_cfg   <= '0;
      exp_cnt  <= '0;
      trig_cnt <= '0;
      to_cnt   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
    end else begin
      if (accept) begin
        rows_cfg <= num_rows;
        cols_cfg <= num_cols;
        exp_cfg  <= exposure_ticks;
        to_cfg   <= timeout_cycles;
      end

      if (accept) begin
        exp_cnt <= '0;
      end else if (state == S_EXPOSE) begin
        exp_cnt <= exp_cnt + EXP_W'(1);
      end

      if ((state == S_TRIG) && (next_state == S_TRIG)) begin
        trig_cnt <= trig_cnt + TW_W'(1);
      end else begin
        trig_cnt <= '0;
      end

      if (((state == S_WAIT_START) || (state == S_WAIT_END)) &&
          (next_state == state)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      // Indices only move when the frame continues; the final pixel and an
      // aborted pixel both leave them where they are.
      if (accept) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if ((state == S_ADVANCE) && (next_state == S_TRIG)) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + ROW_W'(1);
        end else begin
          col_cnt <= col_cnt + COL_W'(1);
        end
      end
    end
  end

  // ---- registered outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      integration <= 1'b0;
      pixel_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      row_idx     <= '0;
      col_idx     <= '0;
    end else begin
      integration <= (state == S_TRIG) && !abort;
      pixel_valid <= (state == S_ADVANCE) && !abort;
      done        <= (state == S_DONE) && !abort;
      busy        <= (state != S_IDLE) && !abort;

      if (accept) begin
        error <= 1'b0;
      end else if (timeout_evt) begin
        error <= 1'b1;
      end

      // During the advance cycle the counters still hold the finished
      // pixel, so the indices line up with pixel_valid.
      if (accept) begin
        row_idx <= '0;
        col_idx <= '0;
      end else begin
        row_idx <= row_cnt;
        col_idx <= col_cnt;
      end
    end
  end

endmodule

// File: tb/tb_cis_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for cis_frame_sequencer. A small CIS_Control model
// answers each integration pulse with a `running` window; a negedge monitor
// records pulse widths, gaps, pixel_valid order and done pulses.
// ---------------------------------------------------------------------------
module tb_cis_frame_sequencer;

  localparam int ROW_W      = 10;
  localparam int COL_W      = 10;
  localparam int EXP_W      = 24;
  localparam int TO_W       = 20;
  localparam int TRIG_WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [ROW_W-1:0] num_rows;
  logic [COL_W-1:0] num_cols;
  logic [EXP_W-1:0] exposure_ticks;
  logic [TO_W-1:0]  timeout_cycles;
  logic             running;
  logic             integration;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic             pixel_valid;
  logic             busy;
  logic             done;
  logic             error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cis_frame_sequencer #(
    .ROW_W(ROW_W), .COL_W(COL_W), .EXP_W(EXP_W), .TO_W(TO_W),
    .TRIG_WIDTH(TRIG_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_rows(num_rows), .num_cols(num_cols),
    .exposure_ticks(exposure_ticks), .timeout_cycles(timeout_cycles),
    .running(running), .integration(integration),
    .row_idx(row_idx), .col_idx(col_idx), .pixel_valid(pixel_valid),
    .busy(busy), .done(done), .error(error)
  );

  // CIS_Control model: running rises 2 cycles after integration falls and
  // stays high 48 cycles. With model_on=0, running follows run_force.
  logic model_on;
  logic run_force;
  int   m_dly;
  int   m_hold;
  logic m_prev;

  always @(negedge clk) begin
    if (!model_on) begin
      running = run_force;
      m_dly = 0; m_hold = 0; m_prev = 1'b0;
    end else if (reset) begin
      running = 1'b0;
      m_dly = 0; m_hold = 0; m_prev = 1'b0;
    end else begin
      if (m_prev && !integration) begin
        m_dly = 2;
      end else if (m_dly > 0) begin
        m_dly = m_dly - 1;
        if (m_dly == 0) begin
          running = 1'b1;
          m_hold = 48;
        end
      end else if (m_hold > 0) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) running = 1'b0;
      end
      m_prev = integration;
    end
  end

  // Monitor, cleared whenever clr_req is bumped.
  int clr_req = 0;
  int clr_ack = 0;
  int cyc, n_rise, n_pulse, n_badw, wid, gap, min_gap;
  int n_pv, n_done, n_overlap, pv_cyc, done_cyc;
  int pv_row [8];
  int pv_col [8];
  logic prev_int;

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      cyc = 0; n_rise = 0; n_pulse = 0; n_badw = 0; wid = 0; gap = 0;
      min_gap = 1000; n_pv = 0; n_done = 0; n_overlap = 0;
      pv_cyc = 0; done_cyc = 0; prev_int = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (integration) begin
        if (!prev_int) begin
          if (n_pulse > 0 && gap < min_gap) min_gap = gap;
          n_rise = n_rise + 1;
        end
        wid = wid + 1;
      end else begin
        if (prev_int) begin
          n_pulse = n_pulse + 1;
          if (wid != TRIG_WIDTH) n_badw = n_badw + 1;
          wid = 0;
          gap = 0;
        end
        gap = gap + 1;
      end
      if (pixel_valid) begin
        if (n_pv < 8) begin
          pv_row[n_pv] = int'(row_idx);
          pv_col[n_pv] = int'(col_idx);
        end
        n_pv = n_pv + 1;
        pv_cyc = cyc;
      end
      if (done) begin
        n_done = n_done + 1;
        done_cyc = cyc;
      end
      if (done && pixel_valid) n_overlap = n_overlap + 1;
      prev_int = integration;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_req = clr_req + 1;
    tick();
  endtask

  // Wait up to budget cycles for a condition; k = cycles taken or -1.
  // which: 0 done high, 1 running high, 2 at least one pixel_valid seen.
  task automatic wait_cond(input int which, input int budget, output int k);
    bit hit;
    k = 0;
    hit = 1'b0;
    while (k < budget && !hit) begin
      tick();
      k++;
      case (which)
        0: hit = (done === 1'b1);
        1: hit = (running === 1'b1);
        default: hit = (n_pv >= 1);
      endcase
    end
    if (!hit) k = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_rows = '0; num_cols = '0; exposure_ticks = '0; timeout_cycles = '0;
    model_on = 1'b0; run_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_integration", 32'(integration), 0);
    reset = 1'b0;
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_error", 32'(error), 0);
    chk("idle_pv", 32'(pixel_valid), 0);
    chk("idle_row", 32'(row_idx), 0);
    chk("idle_col", 32'(col_idx), 0);

    // 2x3 frame, E=10: integration first seen 1+E edges after the start edge.
    model_on = 1'b1;
    num_rows = 2; num_cols = 3; exposure_ticks = 10; timeout_cycles = 0;
    clear_mon();
    pulse_start();
    tick();
    chk("a_busy", 32'(busy), 1);
    k = 1;
    while (!integration && k < 100) begin tick(); k++; end
    chk("a_int_rise", k, 11);
    wait_cond(0, 2000, k);
    chk("a_done_seen", 32'(k >= 0), 1);
    tick();
    chk("a_busy_fall", 32'(busy), 0);
    chk("a_pulses", n_pulse, 6);
    chk("a_bad_widths", n_badw, 0);
    chk("a_min_gap_ge3", 32'(min_gap >= 3), 1);
    chk("a_pv_count", n_pv, 6);
    for (int i = 0; i < 6; i++) begin
      chk("a_pv_row", pv_row[i], i / 3);
      chk("a_pv_col", pv_col[i], i % 3);
    end
    chk("a_done_count", n_done, 1);
    chk("a_done_after_pv", done_cyc - pv_cyc, 1);
    chk("a_overlap", n_overlap, 0);
    chk("a_error", 32'(error), 0);

    // Zero-size frame: done one cycle after start, no integration.
    num_rows = 0; num_cols = 3; exposure_ticks = 10;
    clear_mon();
    pulse_start();
    tick();
    chk("b_done", 32'(done), 1);
    chk("b_busy", 32'(busy), 1);
    tick();
    chk("b_done_drop", 32'(done), 0);
    chk("b_busy_drop", 32'(busy), 0);
    repeat (20) tick();
    chk("b_no_integration", n_rise, 0);
    chk("b_done_count", n_done, 1);

    // E=0, 1x1: integration rises at the edge after the start edge.
    num_rows = 1; num_cols = 1; exposure_ticks = 0;
    clear_mon();
    pulse_start();
    chk("c_int_start_edge", 32'(integration), 0);
    tick();
    chk("c_int_next_edge", 32'(integration), 1);
    wait_cond(0, 300, k);
    chk("c_done_seen", 32'(k >= 0), 1);
    chk("c_pv_count", n_pv, 1);
    chk("c_pv_rc", 32'(pv_row[0] + pv_col[0]), 0);
    chk("c_pulses", n_pulse, 1);

    // Timeout 100 with running held low: 8 trigger cycles then 100 waiting.
    model_on = 1'b0; run_force = 1'b0;
    num_rows = 1; num_cols = 1; exposure_ticks = 0; timeout_cycles = 100;
    clear_mon();
    pulse_start();
    k = 0;
    while (!error && k < 300) begin tick(); k++; end
    chk("d_timeout_cycles", k, TRIG_WIDTH + 100);
    tick();
    chk("d_busy_fall", 32'(busy), 0);
    repeat (10) tick();
    chk("d_no_done", n_done, 0);
    chk("d_no_pv", n_pv, 0);
    chk("d_error_sticky", 32'(error), 1);
    num_rows = 0; timeout_cycles = 0;
    pulse_start();
    chk("d_error_cleared", 32'(error), 0);
    repeat (3) tick();

    // Timeout disabled, running stuck high for 10000 cycles.
    run_force = 1'b1;
    num_rows = 1; num_cols = 1; exposure_ticks = 0; timeout_cycles = 0;
    clear_mon();
    pulse_start();
    repeat (10000) tick();
    chk("e_no_error", 32'(error), 0);
    chk("e_still_busy", 32'(busy), 1);
    chk("e_no_done_yet", n_done, 0);
    run_force = 1'b0;
    wait_cond(0, 50, k);
    chk("e_done_seen", 32'(k >= 0), 1);
    chk("e_pv_count", n_pv, 1);
    chk("e_error_after", 32'(error), 0);

    // Mid-frame start and config change ignored; abort in second WAIT_END.
    model_on = 1'b1;
    num_rows = 2; num_cols = 3; exposure_ticks = 5; timeout_cycles = 0;
    repeat (5) tick();
    clear_mon();
    pulse_start();
    num_rows = 0; exposure_ticks = 50;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 2;
    while (!integration && k < 100) begin tick(); k++; end
    chk("f_int_rise", k, 6);
    wait_cond(2, 500, k);
    chk("f_first_pv", 32'(k >= 0), 1);
    wait_cond(1, 100, k);
    chk("f_running_seen", 32'(k >= 0), 1);
    repeat (5) tick();
    chk("f_busy_before_abort", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("f_abort_busy", 32'(busy), 0);
    chk("f_abort_int", 32'(integration), 0);
    repeat (200) tick();
    chk("f_pv_count", n_pv, 1);
    chk("f_no_done", n_done, 0);
    chk("f_error", 32'(error), 0);
    chk("f_pulses", n_rise, 2);

    // Abort during TRIG drops integration at the next edge.
    num_rows = 1; num_cols = 1; exposure_ticks = 0;
    clear_mon();
    pulse_start();
    tick(); tick();
    chk("g_int_high", 32'(integration), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("g_int_drop", 32'(integration), 0);
    chk("g_busy_drop", 32'(busy), 0);

    // start and abort together in IDLE: nothing happens.
    repeat (60) tick();
    clear_mon();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (20) tick();
    chk("h_busy", 32'(busy), 0);
    chk("h_no_integration", n_rise, 0);

    // Asynchronous reset during WAIT_END of the second pixel.
    num_rows = 1; num_cols = 2; exposure_ticks = 0;
    clear_mon();
    pulse_start();
    wait_cond(2, 300, k);
    chk("i_first_pv", 32'(k >= 0), 1);
    wait_cond(1, 100, k);
    chk("i_running_seen", 32'(k >= 0), 1);
    repeat (5) tick();
    chk("i_col_before", 32'(col_idx), 1);
    chk("i_busy_before", 32'(busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("i_rst_busy", 32'(busy), 0);
    chk("i_rst_col", 32'(col_idx), 0);
    chk("i_rst_row", 32'(row_idx), 0);
    chk("i_rst_int", 32'(integration), 0);
    chk("i_rst_pv_done_err", 32'({pixel_valid, done, error}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    num_rows = 1; num_cols = 1;
    clear_mon();
    pulse_start();
    wait_cond(0, 300, k);
    chk("i_after_done", 32'(k >= 0), 1);
    chk("i_after_pv", n_pv, 1);
    chk("i_after_error", 32'(error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
